// File: rtl/cnn_layer_sequencer.sv
`default_nettype none
// ============================================================================
// cnn_layer_sequencer : steps a one-hot enable through a chain of CNN layers,
// honouring per-run bypass mask, per-layer timeout and abort.   Rev 1.0
// ============================================================================
module cnn_layer_sequencer #(
  parameter int NUM_LAYERS    = 4,
  parameter int TIMEOUT_WIDTH = 16,
  localparam int LW = ($clog2(NUM_LAYERS) > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_LAYERS-1:0]    layer_bypass,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_limit,
  input  logic                     abort,
  input  logic [NUM_LAYERS-1:0]    layer_done,
  output logic [NUM_LAYERS-1:0]    layer_enable,
  output logic [NUM_LAYERS-1:0]    layer_start,
  output logic [LW-1:0]            active_layer,
  output logic                     busy,
  output logic                     cnn_done,
  output logic                     error,
  output logic [1:0]               error_code
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_COMPLETE = 2'd2,
    S_FAULT    = 2'd3
  } state_t;

  localparam logic [1:0] C_ERR_NONE    = 2'b00;
  localparam logic [1:0] C_ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] C_ERR_ABORT   = 2'b10;

  state_t                   state_q, state_d;
  logic [NUM_LAYERS-1:0]    bypass_q, bypass_d;
  logic [NUM_LAYERS-1:0]    enable_q, enable_d;
  logic [NUM_LAYERS-1:0]    lstart_q, lstart_d;
  logic [TIMEOUT_WIDTH-1:0] limit_q, limit_d;
  logic [TIMEOUT_WIDTH-1:0] count_q, count_d;
  logic [LW-1:0]            active_q, active_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic [1:0]               code_q, code_d;

  logic [LW:0]              first_sel;
  logic [LW:0]              next_sel;
  logic                     active_done;
  logic                     timeout_hit;

  // Returns {found, index} of the lowest non-bypassed layer at or above 'from'.
  function automatic logic [LW:0] find_layer(input logic [NUM_LAYERS-1:0] byp,
                                             input int from);
    logic [LW:0] r;
    r = '0;
    for (int j = NUM_LAYERS - 1; j >= 0; j--) begin
      if (j >= from && !byp[j]) r = {1'b1, LW'(j)};
    end
    return r;
  endfunction

  assign first_sel   = find_layer(layer_bypass, 0);
  assign next_sel    = find_layer(bypass_q, int'(active_q) + 1);
  assign active_done = layer_done[active_q];
  assign timeout_hit = (limit_q != '0) && (count_q == limit_q - TIMEOUT_WIDTH'(1));

  always_comb begin
    state_d  = state_q;
    bypass_d = bypass_q;
    limit_d  = limit_q;
    enable_d = enable_q;
    lstart_d = '0;
    count_d  = count_q;
    active_d = active_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    code_d   = code_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          bypass_d = layer_bypass;
          limit_d  = timeout_limit;
          error_d  = 1'b0;
          code_d   = C_ERR_NONE;
          count_d  = '0;
          if (first_sel[LW]) begin
            state_d  = S_RUN;
            active_d = first_sel[LW-1:0];
            enable_d = NUM_LAYERS'(1) << first_sel[LW-1:0];
            lstart_d = NUM_LAYERS'(1) << first_sel[LW-1:0];
            busy_d   = 1'b1;
          end else begin
            state_d = S_COMPLETE;
            done_d  = 1'b1;
          end
        end
      end

      S_RUN: begin
        // Leaving RUN by any path drops the enable and index together.
        if (abort || active_done || timeout_hit) begin
          enable_d = '0;
          active_d = '0;
          busy_d   = 1'b0;
          count_d  = '0;
        end
        if (abort) begin
          state_d = S_FAULT;
          error_d = 1'b1;
          code_d  = C_ERR_ABORT;
        end else if (active_done) begin
          if (next_sel[LW]) begin
            active_d = next_sel[LW-1:0];
            enable_d = NUM_LAYERS'(1) << next_sel[LW-1:0];
            lstart_d = NUM_LAYERS'(1) << next_sel[LW-1:0];
            busy_d   = 1'b1;
          end else begin
            state_d = S_COMPLETE;
            done_d  = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = S_FAULT;
          error_d = 1'b1;
          code_d  = C_ERR_TIMEOUT;
        end else if (count_q != '1) begin
          count_d = count_q + TIMEOUT_WIDTH'(1);
        end
      end

      S_COMPLETE: state_d = S_IDLE;
      S_FAULT:    state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      bypass_q <= '0;
      limit_q  <= '0;
      enable_q <= '0;
      lstart_q <= '0;
      count_q  <= '0;
      active_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      code_q   <= C_ERR_NONE;
    end else begin
      state_q  <= state_d;
      bypass_q <= bypass_d;
      limit_q  <= limit_d;
      enable_q <= enable_d;
      lstart_q <= lstart_d;
      count_q  <= count_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      code_q   <= code_d;
    end
  end

  assign layer_enable = enable_q;
  assign layer_start  = lstart_q;
  assign active_layer = active_q;
  assign busy         = busy_q;
  assign cnn_done     = done_q;
  assign error        = error_q;
  assign error_code   = code_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_sequencer.sv
`default_nettype none
// ============================================================================
// tb_cnn_layer_sequencer : table-driven run scenarios with a layer-start
// scoreboard, plus hand-written abort and mid-run reset sequences.   Rev 1.0
// ============================================================================
module tb_cnn_layer_sequencer;
  localparam int N     = 4;
  localparam int TW    = 16;
  localparam int NEVER = 255;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [N-1:0]  layer_bypass, layer_done, layer_enable, layer_start;
  logic [TW-1:0] timeout_limit;
  logic [1:0]    active_layer;
  logic          busy, cnn_done, error;
  logic [1:0]    error_code;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cnn_layer_sequencer #(.NUM_LAYERS(N), .TIMEOUT_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .start(start), .layer_bypass(layer_bypass),
    .timeout_limit(timeout_limit), .abort(abort), .layer_done(layer_done),
    .layer_enable(layer_enable), .layer_start(layer_start),
    .active_layer(active_layer), .busy(busy), .cnn_done(cnn_done),
    .error(error), .error_code(error_code)
  );

  typedef struct {
    string         name;
    logic [N-1:0]  bypass;
    logic [TW-1:0] limit;
    int            delay;      // enable cycles after layer_start before done
    bit            exp_done;   // 1 = cnn_done, 0 = fault
    logic [1:0]    exp_code;
    int            exp_starts;
    int            exp_total;  // cycle (after start edge) of the end event
  } vec_t;

  typedef struct {
    int idx;
    int cycles;
  } sb_t;

  sb_t sb_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] enc(input logic [N-1:0] v);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  task automatic run_case(input vec_t v);
    int  cyc, cur_cnt, exp_cyc, n_starts;
    bit  in_layer, finished, hit;
    sb_t e;
    sb_q.delete();
    for (int i = 0; i < N; i++) begin
      if (!v.bypass[i]) begin
        if (v.delay == NEVER || (v.limit != 0 && v.delay >= int'(v.limit))) begin
          sb_q.push_back('{idx: i, cycles: int'(v.limit)});
          break;
        end
        sb_q.push_back('{idx: i, cycles: v.delay + 1});
      end
    end
    @(negedge clk);
    start = 1'b1; abort = 1'b0;
    layer_bypass = v.bypass; timeout_limit = v.limit;
    layer_done = N'($urandom);
    cyc = 0; cur_cnt = 0; exp_cyc = 0; n_starts = 0;
    in_layer = 1'b0; finished = 1'b0;
    while (!finished && cyc < 200) begin
      @(negedge clk);
      cyc++;
      check({v.name, " busy"}, busy, layer_enable != '0);
      check({v.name, " onehot"}, $onehot0(layer_enable), 1);
      check({v.name, " active_layer"}, active_layer, busy ? enc(layer_enable) : 2'd0);
      check({v.name, " start_in_enable"}, layer_start & ~layer_enable, 0);
      if (layer_start != '0) begin
        if (in_layer) check({v.name, " layer_cycles"}, cur_cnt, exp_cyc);
        n_starts++;
        if (sb_q.size() == 0) begin
          check({v.name, " unexpected_layer_start"}, layer_start, 0);
        end else begin
          e = sb_q.pop_front();
          check({v.name, " layer_start_idx"}, layer_start, 1 << e.idx);
          exp_cyc = e.cycles;
        end
        if (n_starts == 1) check({v.name, " first_enable_latency"}, cyc, 1);
        in_layer = 1'b1;
        cur_cnt  = 0;
      end
      if (layer_enable != '0) begin
        cur_cnt++;
      end else if (in_layer) begin
        check({v.name, " layer_cycles"}, cur_cnt, exp_cyc);
        in_layer = 1'b0;
      end
      if (cnn_done || error) begin
        finished = 1'b1;
        check({v.name, " cnn_done"}, cnn_done, v.exp_done);
        check({v.name, " error"}, error, v.exp_code != 2'b00);
        check({v.name, " error_code"}, error_code, v.exp_code);
        check({v.name, " end_cycle"}, cyc, v.exp_total);
        check({v.name, " n_layer_starts"}, n_starts, v.exp_starts);
        check({v.name, " scoreboard_empty"}, sb_q.size(), 0);
      end
      // Mid-run start and input changes must have no effect.
      start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (busy) begin
        layer_bypass  = N'($urandom);
        timeout_limit = TW'($urandom);
      end
      hit = (layer_enable != '0) && (cur_cnt - 1 == v.delay);
      layer_done = (N'($urandom) & ~layer_enable) | (hit ? layer_enable : '0);
    end
    if (!finished) check({v.name, " run_timeout"}, 0, 1);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  vec_t vecs[10];
  bit   seen;

  initial begin
    vecs[0] = '{"all_layers",    4'b0000, 16'd0, 3,     1'b1, 2'b00, 4, 17};
    vecs[1] = '{"bypass_0101",   4'b0101, 16'd0, 3,     1'b1, 2'b00, 2, 9};
    vecs[2] = '{"bypass_all",    4'b1111, 16'd0, 3,     1'b1, 2'b00, 0, 1};
    vecs[3] = '{"timeout_5",     4'b0000, 16'd5, NEVER, 1'b0, 2'b01, 1, 6};
    vecs[4] = '{"done_on_last",  4'b0000, 16'd5, 4,     1'b1, 2'b00, 4, 21};
    vecs[5] = '{"zero_gap",      4'b0000, 16'd0, 0,     1'b1, 2'b00, 4, 5};
    vecs[6] = '{"bypass_1000",   4'b1000, 16'd2, 1,     1'b1, 2'b00, 3, 7};
    vecs[7] = '{"timeout_3",     4'b0110, 16'd3, 3,     1'b0, 2'b01, 1, 4};
    vecs[8] = '{"limit1_done",   4'b1110, 16'd1, 0,     1'b1, 2'b00, 1, 2};
    vecs[9] = '{"limit1_expire", 4'b0111, 16'd1, NEVER, 1'b0, 2'b01, 1, 2};

    reset = 1'b1; start = 1'b1; abort = 1'b1;
    layer_bypass = '0; timeout_limit = 16'd3; layer_done = '1;
    repeat (2) @(negedge clk);
    check("reset enable", layer_enable, 0);
    check("reset layer_start", layer_start, 0);
    check("reset active", active_layer, 0);
    check("reset busy", busy, 0);
    check("reset cnn_done", cnn_done, 0);
    check("reset error", {error, error_code}, 0);
    reset = 1'b0; start = 1'b0; abort = 1'b0; layer_done = '0;
    @(negedge clk);

    for (int k = 0; k < 10; k++) run_case(vecs[k]);

    // Abort coinciding with done of the active layer.
    start = 1'b1; layer_bypass = '0; timeout_limit = '0; layer_done = '0;
    @(negedge clk);
    start = 1'b0;
    check("abort setup layer_start", layer_start, 4'b0001);
    abort = 1'b1; layer_done = 4'b0001;
    @(negedge clk);
    layer_done = '0;
    check("abort error", error, 1);
    check("abort code", error_code, 2'b10);
    check("abort cnn_done", cnn_done, 0);
    check("abort enable", {busy, layer_enable}, 0);
    repeat (2) @(negedge clk);
    check("abort idle ignored error", error, 1);
    check("abort idle ignored code", error_code, 2'b10);
    check("abort idle ignored busy", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start beats abort", layer_start, 4'b0001);
    check("start clears error", {error, error_code}, 0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      layer_done = layer_enable;
      @(negedge clk);
      if (cnn_done) seen = 1'b1;
    end
    check("post-abort run completes", seen, 1);
    layer_done = '0;
    @(negedge clk);

    // Reset while layer 2 is active.
    start = 1'b1; layer_bypass = '0; timeout_limit = '0;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (busy && active_layer == 2'd2) seen = 1'b1;
      else begin
        layer_done = layer_enable;
        @(negedge clk);
      end
    end
    check("reached layer 2", seen, 1);
    layer_done = '0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrun reset enable", layer_enable, 0);
    check("midrun reset outs", {layer_start, active_layer, busy, cnn_done, error, error_code}, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("after reset starts layer 0", layer_start, 4'b0001);
    check("after reset active 0", active_layer, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("after reset abort code", error_code, 2'b10);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/cnn_layer_sequencer.md
CNN_LAYER_SEQUENCER -- requirements
Module: cnn_layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, number of sequenced layers (legal 2..16).
REQ-002 SHALL have parameter TIMEOUT_WIDTH, default 16, width of per-layer timeout counter/limit.
REQ-003 SHALL have localparam LW = max(1, $clog2(NUM_LAYERS)), width of layer index.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request to run the layer chain; honoured only in IDLE.
REQ-007 layer_bypass  in  NUM_LAYERS  bit i=1 skips layer i; sampled on accepted start.
REQ-008 timeout_limit  in  TIMEOUT_WIDTH  max enable cycles per layer, 0 = no timeout; sampled on accepted start.
REQ-009 abort  in  1  terminate current run.
REQ-010 layer_done  in  NUM_LAYERS  per-layer completion, bit i from layer i.
REQ-011 layer_enable  out  NUM_LAYERS  one-hot enable of the active layer, else 0.
REQ-012 layer_start  out  NUM_LAYERS  one-cycle pulse on first enable cycle of a layer.
REQ-013 active_layer  out  LW  index of active layer; 0 when not in RUN.
REQ-014 busy  out  1  high in RUN.
REQ-015 cnn_done  out  1  one-cycle pulse on successful completion.
REQ-016 error  out  1  sticky fault flag, cleared by accepted start.
REQ-017 error_code  out  2  00 none, 01 timeout, 10 abort; sticky with error.

Function
REQ-018 FSM states SHALL be IDLE, RUN, COMPLETE, FAULT; all outputs registered.
REQ-019 IDLE + start SHALL latch bypass and limit, clear error/error_code, select lowest non-bypassed index.
REQ-020 If all layers bypassed, accepted start SHALL go to COMPLETE (cnn_done one cycle after start edge, no layer enabled).
REQ-021 Otherwise next cycle SHALL be RUN: layer_enable and layer_start of selected layer high, busy high (start at edge k -> enable at k+1).
REQ-022 In RUN, layer_enable SHALL stay on active layer until its done, timeout or abort; layer_start high only on first cycle.
REQ-023 layer_done of the active layer SHALL be accepted on any RUN cycle, including the layer_start cycle; done bits of other layers ignored.
REQ-024 On accepted done, if a higher non-bypassed layer exists, next cycle SHALL enable it with layer_start (zero-gap hop); else go to COMPLETE.
REQ-025 COMPLETE SHALL last exactly one cycle with cnn_done=1, busy=0, layer_enable=0, then IDLE.
REQ-026 Timeout counter SHALL clear on each layer_start cycle, increment each RUN cycle, saturate at all-ones.
REQ-027 With limit L!=0, if no done by counter value L-1, SHALL enter FAULT next cycle, code 01; layer gets exactly L enable cycles; done on that last cycle wins.
REQ-028 abort in RUN SHALL enter FAULT next cycle, code 10; abort priority over done and timeout in same cycle.
REQ-029 abort in IDLE or COMPLETE SHALL be ignored; abort with start in IDLE: start wins.
REQ-030 FAULT SHALL last one cycle, outputs as COMPLETE but cnn_done=0, error=1, then IDLE; error/error_code hold until next accepted start.
REQ-031 start outside IDLE SHALL be ignored; bypass/limit changes during a run SHALL have no effect.

Reset
REQ-032 reset SHALL force IDLE and zero layer_enable, layer_start, active_layer, busy, cnn_done, error, error_code, counter, latched bypass/limit on the next edge, overriding all inputs including mid-run.

Verification
REQ-033 NUM_LAYERS=4, bypass=0000, limit=0, each done 3 cycles after its layer_start -> enables 0,1,2,3 in order, 4 layer_start pulses, cnn_done 1 cycle after layer 3 done.
REQ-034 bypass=0101 -> only layers 1 and 3 enabled, active_layer 1 then 3, cnn_done once.
REQ-035 bypass=1111 -> cnn_done at start+1, layer_enable never high, busy never high.
REQ-036 limit=5, layer 0 never done -> layer_enable[0] high 5 cycles, FAULT, error=1, code 01; done on 5th cycle instead -> no error, hop to layer 1.
REQ-037 abort and layer_done[active] same RUN cycle -> FAULT, code 10, cnn_done stays 0; next start clears error.
REQ-038 reset asserted mid-RUN of layer 2 -> next edge all outputs 0, state IDLE; subsequent start runs from layer 0.
